// File: rtl/ifetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage and its neighbours.
// NOP_INSTR is also used by decode to fill bubbles.
package ifetch_stage_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

  typedef enum logic [1:0] {
    IF_STATE_RUN    = 2'b00,
    IF_STATE_FLUSH  = 2'b01,
    IF_STATE_HALTED = 2'b10
  } if_state_t;

  // One fetched instruction together with the address it came from.
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

  // Force a byte address onto a word boundary.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifetch_stage_if.sv
// Instruction-memory bus: valid/ready request channel and an in-order,
// always-accepted response channel. The fetch stage is the master.
interface ifetch_stage_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] addr;
  logic        rsp_valid;
  logic [31:0] rsp_data;

  modport master (
    output req_valid,
    output addr,
    input  req_ready,
    input  rsp_valid,
    input  rsp_data
  );

  modport slave (
    input  req_valid,
    input  addr,
    output req_ready,
    output rsp_valid,
    output rsp_data
  );
endinterface

// File: rtl/ifetch_stage_fetch_queue.sv
// fetch_queue: small synchronous FIFO with flush. Storage is a register
// array read combinationally so a word pushed in one cycle is visible at
// the head in the next one. Push while full is accepted only alongside a pop.
module fetch_queue #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_data,
  input  logic                   i_pop,
  input  logic                   i_flush,
  output logic [WIDTH-1:0]       o_data,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW:0]   CNT_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0]   CNT_MAX = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CNT_MAX);
  assign o_count = r_count;
  assign o_data  = r_mem[r_rd_ptr];
  assign w_pop   = i_pop & ~o_empty;
  assign w_push  = i_push & (~o_full | w_pop);

  // Storage write; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (w_push & ~i_flush) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointer and occupancy bookkeeping; flush empties the queue at once.
  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      if (w_push && !w_pop)      r_count <= r_count + CNT_ONE;
      else if (w_pop && !w_push) r_count <= r_count - CNT_ONE;
    end
  end
endmodule

// File: rtl/ifetch_stage.sv
// ifetch_stage: owns the PC, issues word fetches and hands {instr, pc} to
// decode through a small queue. Redirects flush the queue and drop responses
// to requests issued before the redirect.
// Build option: IFETCH_MISALIGN_HALT_EN - when defined, a redirect to a
// non-word-aligned target halts fetch; otherwise the low bits are cleared.
module ifetch_stage
  import ifetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          QDEPTH   = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           stall_in,
  input  logic           redirect_in,
  input  logic [31:0]    redirect_pc_in,
  input  logic           halt_in,
  ifetch_stage_if.master imem,
  output logic           valid_out_if,
  output logic [31:0]    instr_out_if,
  output logic [31:0]    pc_out_if,
  output logic           halt_out_if
);
  localparam int CW = $clog2(QDEPTH) + 1;
  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW:0]   CAP     = (CW+1)'(QDEPTH);

  if_state_t     r_state;
  if_state_t     w_state_next;
  logic [31:0]   r_pc;
  logic [CW-1:0] r_outstanding;
  logic [CW-1:0] r_drop;
  logic [CW-1:0] w_out_next;
  logic [CW-1:0] w_drop_next;

  logic          w_accept;
  logic          w_keep_rsp;
  logic          w_misalign;
  logic          w_halt_evt;
  logic          w_redirect;
  logic          w_pop;
  logic          w_room;
  logic [31:0]   w_target;

  fetch_entry_t  w_head;
  logic          w_q_full;
  logic          w_q_empty;
  logic [CW-1:0] w_q_count;
  logic [31:0]   w_tag_pc;
  logic          w_tag_full;
  logic          w_tag_empty;
  logic [CW-1:0] w_tag_count;
  logic          w_unused_status;

`ifdef IFETCH_MISALIGN_HALT_EN
  assign w_misalign = redirect_in & (redirect_pc_in[1:0] != 2'b00);
`else
  assign w_misalign = 1'b0;
`endif

  // Halt (explicit or misaligned target) outranks a redirect; once halted,
  // redirects are ignored until reset.
  assign w_halt_evt = halt_in | w_misalign;
  assign w_redirect = redirect_in & ~w_halt_evt & (r_state != IF_STATE_HALTED);
  assign w_target   = align_word(redirect_pc_in);
  assign w_accept   = imem.req_valid & imem.req_ready;
  assign w_keep_rsp = imem.rsp_valid & (r_drop == '0) & (r_state != IF_STATE_HALTED);
  assign w_pop      = valid_out_if & ~stall_in & ~redirect_in;
  // Outstanding requests plus queued words must leave room for one more.
  assign w_room     = ({1'b0, r_outstanding} + {1'b0, w_q_count}) < CAP;

  assign w_unused_status = ^{w_q_full, w_tag_empty, w_tag_count, redirect_pc_in[1:0]};

  fetch_queue #(.DEPTH(QDEPTH), .WIDTH(64)) u_queue (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_keep_rsp),
    .i_data  ({imem.rsp_data, w_tag_pc}),
    .i_pop   (w_pop),
    .i_flush (w_redirect),
    .o_data  (w_head),
    .o_full  (w_q_full),
    .o_empty (w_q_empty),
    .o_count (w_q_count)
  );

  // In-order record of the PC of every request still owed a kept response.
  fetch_queue #(.DEPTH(QDEPTH), .WIDTH(32)) u_tags (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_accept),
    .i_data  (r_pc),
    .i_pop   (w_keep_rsp),
    .i_flush (w_redirect),
    .o_data  (w_tag_pc),
    .o_full  (w_tag_full),
    .o_empty (w_tag_empty),
    .o_count (w_tag_count)
  );

  // Next values of the in-flight and to-be-dropped response counters.
  always_comb begin
    w_out_next = r_outstanding;
    if (w_accept)       w_out_next = w_out_next + CNT_ONE;
    if (imem.rsp_valid) w_out_next = w_out_next - CNT_ONE;
    w_drop_next = r_drop;
    if (w_redirect)                           w_drop_next = w_out_next;
    else if (imem.rsp_valid && r_drop != '0) w_drop_next = r_drop - CNT_ONE;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IF_STATE_RUN;
    else     r_state <= w_state_next;
  end

  // FSM next state: redirect with responses still owed goes to FLUSH until
  // they have all been discarded; halt is terminal.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IF_STATE_RUN: begin
        if (w_redirect && w_out_next != '0) w_state_next = IF_STATE_FLUSH;
      end
      IF_STATE_FLUSH: begin
        if (w_drop_next == '0) w_state_next = IF_STATE_RUN;
      end
      default: w_state_next = IF_STATE_HALTED;
    endcase
    if (w_halt_evt) w_state_next = IF_STATE_HALTED;
  end

  // FSM outputs: request issue and the decode-facing bundle.
  always_comb begin
    imem.req_valid = (r_state == IF_STATE_RUN) & ~redirect_in & w_room & ~w_tag_full;
    imem.addr      = r_pc;
    valid_out_if   = ~w_q_empty & (r_state != IF_STATE_HALTED);
    instr_out_if   = valid_out_if ? w_head.instr : NOP_INSTR;
    pc_out_if      = valid_out_if ? w_head.pc : r_pc;
    halt_out_if    = (r_state == IF_STATE_HALTED);
  end

  // PC and response-accounting registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc          <= RESET_PC;
      r_outstanding <= '0;
      r_drop        <= '0;
    end else begin
      if (w_redirect)    r_pc <= w_target;
      else if (w_accept) r_pc <= r_pc + 32'd4;
      r_outstanding <= w_out_next;
      r_drop        <= w_drop_next;
    end
  end
endmodule
